// File: rtl/instruction_cache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hits, block refill from a
// 128-bit instruction memory, and a flush that invalidates every line.
module instruction_cache_responder #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 32 - 4 - INDEX_BITS,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  address,
  input  logic         flush,
  output logic [31:0]  readinst,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam logic [31:0] RESET_PC = 32'hFFFFFFFC;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];
  logic [127:0]          fill_data_q;
  logic [27:0]           mem_address_q;
  logic                  mem_read_q;
  logic                  flush_pending_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            req_word;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  is_sentinel;
  logic                  hit;
  logic                  miss;
  logic [31:0]           line_words [4];

  assign req_index   = address[3+INDEX_BITS:4];
  assign req_tag     = address[31:4+INDEX_BITS];
  assign req_word    = address[3:2];
  assign fill_index  = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag    = mem_address_q[27:INDEX_BITS];
  assign is_sentinel = (address == RESET_PC);

  assign hit  = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign miss = (state_q == IDLE) && !is_sentinel && !hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_words
      assign line_words[gi] = data_q[req_index][gi*32 +: 32];
    end
  endgenerate

  // Hits and the reset-PC sentinel answer in the same cycle; reset forces a NOP.
  always_comb begin
    busywait = 1'b0;
    readinst = NOP_INST;
    if (!reset) begin
      if (state_q != IDLE) begin
        busywait = 1'b1;
      end else if (!is_sentinel) begin
        busywait = !hit;
        readinst = line_words[req_word];
      end
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_address_q   <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end
          if (miss) begin
            mem_address_q <= address[31:4];
            mem_read_q    <= 1'b1;
            state_q       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (flush) begin
            flush_pending_q <= 1'b1;
          end
          if (!mem_busywait) begin
            mem_read_q <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          // A flush seen during the refill also wipes the line being filled.
          if (flush || flush_pending_q) begin
            valid_q <= '0;
          end else begin
            valid_q[fill_index] <= 1'b1;
          end
          flush_pending_q <= 1'b0;
          state_q         <= IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Tag/data storage carries no reset; validity alone decides a hit.
  always_ff @(posedge clock) begin
    if (state_q == MEM_READ && !mem_busywait) begin
      fill_data_q <= mem_readdata;
    end
    if (state_q == UPDATE) begin
      data_q[fill_index] <= fill_data_q;
      tag_q[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache_responder.sv
// Cycle-by-cycle vector bench for the instruction cache, with a behavioural block memory
// whose word w of block b reads back as (b << 8) | (w + 1).
module tb_instruction_cache_responder;

  logic         clock;
  logic         reset;
  logic [31:0]  address;
  logic         flush;
  logic [31:0]  readinst;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_vec = 0;
  int n_bad = 0;

  instruction_cache_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .flush        (flush),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] blk(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {b[23:0], 8'(i + 1)};
    return r;
  endfunction

  always_comb mem_readdata = blk(mem_address);

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        mbusy;
    logic        exp_bw;
    logic        exp_mr;
    logic        chk_inst;
    logic [31:0] exp_inst;
    logic        chk_ma;
    logic [27:0] exp_ma;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input logic [31:0] a, input logic f, input logic mb, input logic bw,
                      input logic mr, input logic ci, input logic [31:0] inst,
                      input logic cm, input logic [27:0] ma);
    vec_t v;
    v.addr = a; v.flush = f; v.mbusy = mb; v.exp_bw = bw; v.exp_mr = mr;
    v.chk_inst = ci; v.exp_inst = inst; v.chk_ma = cm; v.exp_ma = ma;
    tbl.push_back(v);
  endtask

  // IDLE answer (hit or sentinel), IDLE miss detect, MEM_READ cycle, UPDATE cycle
  task automatic idle_v(input logic [31:0] a, input logic f, input logic [31:0] inst);
    push(a, f, 1'b0, 1'b0, 1'b0, 1'b1, inst, 1'b0, 28'h0);
  endtask
  task automatic miss_v(input logic [31:0] a, input logic f);
    push(a, f, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 28'h0);
  endtask
  task automatic mrd_v(input logic [31:0] a, input logic f, input logic mb, input logic [27:0] ma);
    push(a, f, mb, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, ma);
  endtask
  task automatic upd_v(input logic [31:0] a, input logic f);
    push(a, f, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 28'h0);
  endtask
  task automatic fill(input logic [31:0] a, input int nbusy);
    miss_v(a, 1'b0);
    for (int i = 0; i < nbusy; i++) mrd_v(a, 1'b0, 1'b1, a[31:4]);
    mrd_v(a, 1'b0, 1'b0, a[31:4]);
    upd_v(a, 1'b0);
  endtask

  task automatic check(input string what, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", what, idx, got, exp);
    end
  endtask

  initial begin
    // sentinel idle cycles
    for (int i = 0; i < 3; i++) idle_v(32'hFFFFFFFC, 1'b0, 32'h00000013);
    // cold miss with 3 busy memory cycles, then same-block hits
    fill(32'h0, 3);
    idle_v(32'h0, 1'b0, 32'h1);
    idle_v(32'h4, 1'b0, 32'h2);
    idle_v(32'h8, 1'b0, 32'h3);
    idle_v(32'hC, 1'b0, 32'h4);
    // conflict on index 1
    fill(32'h10, 0);
    idle_v(32'h10, 1'b0, 32'h101);
    idle_v(32'h14, 1'b0, 32'h102);
    fill(32'h90, 0);
    idle_v(32'h90, 1'b0, 32'h901);
    idle_v(32'h9C, 1'b0, 32'h904);
    fill(32'h10, 0);
    idle_v(32'h10, 1'b0, 32'h101);
    idle_v(32'h0, 1'b0, 32'h1);
    // flush in IDLE on a hit cycle
    idle_v(32'h0, 1'b1, 32'h1);
    fill(32'h0, 0);
    idle_v(32'h0, 1'b0, 32'h1);
    fill(32'h10, 0);
    idle_v(32'h10, 1'b0, 32'h101);
    // flush during MEM_READ
    miss_v(32'h20, 1'b0);
    mrd_v(32'h20, 1'b1, 1'b1, 28'h2);
    mrd_v(32'h20, 1'b0, 1'b0, 28'h2);
    upd_v(32'h20, 1'b0);
    fill(32'h20, 0);
    idle_v(32'h20, 1'b0, 32'h201);
    idle_v(32'h28, 1'b0, 32'h203);
    // flush during UPDATE
    miss_v(32'h70, 1'b0);
    mrd_v(32'h70, 1'b0, 1'b0, 28'h7);
    upd_v(32'h70, 1'b1);
    fill(32'h70, 0);
    idle_v(32'h70, 1'b0, 32'h701);
    // flush and miss together
    miss_v(32'h30, 1'b1);
    mrd_v(32'h30, 1'b0, 1'b0, 28'h3);
    upd_v(32'h30, 1'b0);
    idle_v(32'h30, 1'b0, 32'h301);
    fill(32'h20, 0);
    idle_v(32'h20, 1'b0, 32'h201);
    // address changes mid-miss: latched block still fills
    miss_v(32'h40, 1'b0);
    mrd_v(32'h50, 1'b0, 1'b0, 28'h4);
    upd_v(32'h50, 1'b0);
    idle_v(32'h40, 1'b0, 32'h401);
    fill(32'h50, 0);
    idle_v(32'h50, 1'b0, 32'h501);
    idle_v(32'hFFFFFFFC, 1'b0, 32'h00000013);

    // reset state, with a would-miss address present
    reset = 1'b1; address = 32'h0; flush = 1'b0; mem_busywait = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busywait", 0, {31'h0, busywait}, 32'h0);
    check("reset_readinst", 0, readinst, 32'h00000013);
    check("reset_mem_read", 0, {31'h0, mem_read}, 32'h0);
    check("reset_mem_address", 0, {4'h0, mem_address}, 32'h0);
    address = 32'hFFFFFFFC;
    @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      address = tbl[i].addr;
      flush = tbl[i].flush;
      mem_busywait = tbl[i].mbusy;
      @(negedge clock);
      $display("step %0d addr=%h flush=%b mbusy=%b -> busywait=%b mem_read=%b readinst=%h mem_address=%h",
               i, address, flush, mem_busywait, busywait, mem_read, readinst, mem_address);
      check("busywait", i, {31'h0, busywait}, {31'h0, tbl[i].exp_bw});
      check("mem_read", i, {31'h0, mem_read}, {31'h0, tbl[i].exp_mr});
      if (tbl[i].chk_inst) check("readinst", i, readinst, tbl[i].exp_inst);
      if (tbl[i].chk_ma) check("mem_address", i, {4'h0, mem_address}, {4'h0, tbl[i].exp_ma});
      @(posedge clock);
      #1;
    end

    // reset asserted during MEM_READ
    address = 32'h60; flush = 1'b0; mem_busywait = 1'b1;
    @(negedge clock);
    check("rst_seq_detect_bw", 100, {31'h0, busywait}, 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_seq_mem_read_on", 101, {31'h0, mem_read}, 32'h1);
    check("rst_seq_mem_address", 101, {4'h0, mem_address}, 32'h6);
    #1 reset = 1'b1;
    #1;
    check("rst_seq_mem_read_drop", 102, {31'h0, mem_read}, 32'h0);
    check("rst_seq_busywait", 102, {31'h0, busywait}, 32'h0);
    check("rst_seq_readinst", 102, readinst, 32'h00000013);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst_seq_redetect_bw", 103, {31'h0, busywait}, 32'h1);
    check("rst_seq_redetect_mr", 103, {31'h0, mem_read}, 32'h0);
    @(posedge clock); #1 mem_busywait = 1'b0;
    @(negedge clock);
    check("rst_seq_refill_mr", 104, {31'h0, mem_read}, 32'h1);
    check("rst_seq_refill_ma", 104, {4'h0, mem_address}, 32'h6);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_seq_update_bw", 105, {31'h0, busywait}, 32'h1);
    check("rst_seq_update_mr", 105, {31'h0, mem_read}, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_seq_hit_bw", 106, {31'h0, busywait}, 32'h0);
    check("rst_seq_hit_inst", 106, readinst, 32'h601);
    @(posedge clock); #1 address = 32'h0;
    @(negedge clock);
    check("rst_seq_line0_invalid", 107, {31'h0, busywait}, 32'h1);
    $display("reset-mid-miss sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
